reg_file_stage: RTL

REG_FILE_STAGE -- requirements
Module: reg_file_stage

---
 rtl/reg_file_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/reg_file_stage.sv
// Eight-entry register file with a one-deep registered operand stage feeding the ALU.
// Reads bypass a same-edge write; the operand set is held under downstream backpressure.
module reg_file_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET)   q <= '0;
    else if (we) q <= d;
endmodule

module reg_file_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [2:0]       INADDRESS,
  input  logic             WRITE,
  input  logic [2:0]       OUT1ADDRESS,
  input  logic [2:0]       OUT2ADDRESS,
  input  logic [2:0]       SELECT_IN,
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic [2:0]       SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  localparam int NUM_REGS = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       sel;
  } opset_t;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]            we;
  state_t                         state, state_nxt;
  opset_t                         opset, opset_nxt;
  logic                           accept;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      assign we[g] = WRITE && (INADDRESS == 3'(g));
      reg_file_cell #(.WIDTH(WIDTH)) u_cell (
        .CLK  (CLK),
        .RESET(RESET),
        .we   (we[g]),
        .d    (IN),
        .q    (regs[g])
      );
    end
  endgenerate

  assign OUT_VALID   = (state == FULL);
  assign ISSUE_READY = !OUT_VALID || OUT_READY;
  assign accept      = ISSUE_VALID && ISSUE_READY;

  // Same-edge write forwards straight into the captured operand.
  always_comb begin
    opset_nxt.op1 = (WRITE && INADDRESS == OUT1ADDRESS) ? IN : regs[OUT1ADDRESS];
    opset_nxt.op2 = (WRITE && INADDRESS == OUT2ADDRESS) ? IN : regs[OUT2ADDRESS];
    opset_nxt.sel = SELECT_IN;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (OUT_READY && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= EMPTY;
    else       state <= state_nxt;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET)       opset <= '0;
    else if (accept) opset <= opset_nxt;

  assign OUT1   = opset.op1;
  assign OUT2   = opset.op2;
  assign SELECT = opset.sel;
endmodule
